// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Definitions shared by the pipeline stages: default data/address widths,
// the special instruction words recognised by fetch, and the fetch-stage
// state encoding.
package pipeline_pkg;

    localparam int B_DEFAULT = 32;
    localparam int W_DEFAULT = 7;

    // All-zero word is a harmless bubble for every downstream stage.
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    // All-ones word stops fetching once it has been accepted.
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

endpackage : pipeline_pkg

// File: rtl/pc_register.sv
// pc_register
// W-bit program-counter register with a load enable.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset (clears q to 0)
//   load   in   when high, q takes d on the clock edge
//   d      in   next PC value
//   q      out  current PC value
module pc_register #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule : pc_register

// File: rtl/instruction_fetch.sv
// instruction_fetch
// Fetch stage: owns the PC, addresses the instruction ROM, and hands the
// fetched word plus PC+1 to the IF/ID register. Handles jump/branch
// redirects (with one squashed wrong-path slot), hazard stalls, debug
// run/step gating and HALT detection.
//
// Ports:
//   clk                  in   rising-edge clock
//   rst_n                in   asynchronous active-low reset
//   enable               in   debug run/step gate; low freezes all state
//   stall                in   hazard stall; holds the PC
//   branch_taken         in   branch resolved taken this cycle
//   branch_target        in   branch destination
//   jump_taken           in   jump resolved this cycle (beats branch)
//   jump_target          in   jump destination
//   imem_data            in   ROM word at imem_addr (combinational read)
//   imem_addr            out  current PC
//   pc_incrementado_out  out  PC+1, wrapping at 2^W
//   instruction_out      out  word to IF/ID (NOP when halted or squashed)
//   halted               out  high once HALT has been fetched
//   fetch_count          out  saturating count of accepted fetches
module instruction_fetch
    import pipeline_pkg::*;
#(
    parameter int B     = B_DEFAULT,
    parameter int W     = W_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [W-1:0]     branch_target,
    input  logic             jump_taken,
    input  logic [W-1:0]     jump_target,
    input  logic [B-1:0]     imem_data,
    output logic [W-1:0]     imem_addr,
    output logic [W-1:0]     pc_incrementado_out,
    output logic [B-1:0]     instruction_out,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);

    fetch_state_e     state;
    fetch_state_e     state_next;
    logic [W-1:0]     pc;
    logic [W-1:0]     pc_plus1;
    logic [W-1:0]     pc_next;
    logic             pc_load;
    logic             redirect;
    logic             is_halt_word;
    logic             accept;
    logic [CNT_W-1:0] count;

    assign redirect     = jump_taken | branch_taken;
    assign is_halt_word = (imem_data == B'(HALT_WORD));
    assign pc_plus1     = pc + 1'b1;

    // A fetch is accepted only when the word on imem_data will really move
    // down the pipe: running, enabled, not stalled and not being squashed.
    assign accept = (state == RUN) && enable && !stall && !redirect;

    pc_register #(
        .W (W)
    ) u_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (pc_load),
        .d     (pc_next),
        .q     (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-PC selection, HALT transition and squash. A redirect overrides
    // both stall and HALT detection; the HALT word only counts when it is
    // genuinely accepted, and then the PC parks on it.
    always_comb begin
        state_next      = state;
        pc_load         = 1'b0;
        pc_next         = pc_plus1;
        instruction_out = imem_data;

        if (jump_taken) begin
            pc_next = jump_target;
        end else if (branch_taken) begin
            pc_next = branch_target;
        end

        if ((state == HALTED) || redirect) begin
            instruction_out = B'(NOP_WORD);
        end

        if ((state == RUN) && enable) begin
            if (redirect) begin
                pc_load = 1'b1;
            end else if (!stall) begin
                if (is_halt_word) begin
                    state_next = HALTED;
                end else begin
                    pc_load = 1'b1;
                end
            end
        end
    end

    // Accepted-fetch counter, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (accept && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign imem_addr           = pc;
    assign pc_incrementado_out = pc_plus1;
    assign halted              = (state == HALTED);
    assign fetch_count         = count;

endmodule : instruction_fetch
